// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_responder                                               |
// | Description : Word-organised data memory behind the load/store unit's      |
// |               cs/wr/mask interface, with wait states and range faults.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        wr,
    input  logic [3:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] data_wr,
    output logic [31:0] data_rd,
    output logic        stall,
    output logic        fault
);

    localparam int unsigned c_AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] c_LO    = {1'b0, BASE_ADDR};
    localparam logic [32:0] c_HI    = c_LO + (33'(DEPTH_WORDS) << 2);
    localparam logic [2:0]  c_WLOAD = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [2:0]      r_wcnt;
    logic            r_wr;
    logic            r_inr;
    logic [3:0]      r_mask;
    logic [31:0]     r_data;
    logic [c_AW-1:0] r_idx;
    logic [31:0]     r_data_rd;
    logic            r_fault;
    logic [31:0]     r_mem [DEPTH_WORDS];

    logic            w_inr;
    logic [c_AW-1:0] w_idx;
    logic            w_accept;
    logic            w_commit;
    logic            w_use_in;
    logic            w_c_wr;
    logic            w_c_inr;
    logic [3:0]      w_c_mask;
    logic [31:0]     w_c_data;
    logic [c_AW-1:0] w_c_idx;

    // 33-bit compare so a window ending exactly at 2^32 is representable
    assign w_inr    = ({1'b0, addr} >= c_LO) && ({1'b0, addr} < c_HI);
    assign w_idx    = c_AW'(({1'b0, addr} - c_LO) >> 2);
    assign w_accept = (r_state == c_IDLE) && !cs;
    assign w_commit = (w_next == c_DONE) && (r_state != c_DONE);

    // With zero wait states the commit happens on the accepting edge, before
    // the request registers hold anything, so take the live inputs then.
    assign w_use_in = (r_state == c_IDLE);
    assign w_c_wr   = w_use_in ? wr      : r_wr;
    assign w_c_inr  = w_use_in ? w_inr   : r_inr;
    assign w_c_mask = w_use_in ? mask    : r_mask;
    assign w_c_data = w_use_in ? data_wr : r_data;
    assign w_c_idx  = w_use_in ? w_idx   : r_idx;

    assign stall   = !rst && (w_accept || (r_state == c_BUSY));
    assign data_rd = r_data_rd;
    assign fault   = r_fault;

    always_comb begin
        w_next = c_IDLE;
        case (r_state)
            c_IDLE: begin
                if (!cs) begin
                    w_next = (WAIT_STATES == 0) ? c_DONE : c_BUSY;
                end
            end
            c_BUSY:  w_next = (r_wcnt == 3'd0) ? c_DONE : c_BUSY;
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_wcnt  <= 3'd0;
        end else begin
            r_state <= w_next;
            if (w_accept && (WAIT_STATES != 0)) begin
                r_wcnt <= c_WLOAD;
            end else if ((r_state == c_BUSY) && (r_wcnt != 3'd0)) begin
                r_wcnt <= r_wcnt - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr   <= 1'b1;
            r_inr  <= 1'b0;
            r_mask <= 4'd0;
            r_data <= 32'd0;
            r_idx  <= '0;
        end else if (w_accept) begin
            r_wr   <= wr;
            r_inr  <= w_inr;
            r_mask <= mask;
            r_data <= data_wr;
            r_idx  <= w_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_rd <= 32'd0;
            r_fault   <= 1'b0;
        end else begin
            r_fault <= w_commit && !w_c_inr;
            if (w_commit && w_c_wr) begin
                r_data_rd <= w_c_inr ? r_mem[w_c_idx] : 32'd0;
            end
        end
    end

    // Storage is deliberately not reset; a reset only suppresses the commit.
    always_ff @(posedge clk) begin
        if (!rst && w_commit && !w_c_wr && w_c_inr) begin
            for (int i = 0; i < 4; i++) begin
                if (w_c_mask[i]) begin
                    r_mem[w_c_idx][8*i +: 8] <= w_c_data[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Word-organised data memory that answers the load/store unit's chip-select/write/mask request interface. It sits at the memory end of the MW stage and services one access at a time: byte-masked writes and full-word reads. A configurable number of wait states holds the pipeline through a `stall` handshake. Accesses outside the mapped window are rejected and flagged.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, 16..65536.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; 4-byte aligned.
- `WAIT_STATES`, 1: extra busy cycles per access, 0..7.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cs`  in  1  chip select, active low; 0 = access requested.
- `wr`  in  1  direction, active low; 0 = store, 1 = load.
- `mask`  in  4  byte enables for stores; bit i enables `data_wr[8i+7:8i]`.
- `addr`  in  32  byte address; bits [1:0] ignored (byte lanes are already placed by the requester).
- `data_wr`  in  32  store data, lane-aligned.
- `data_rd`  out  32  load data, full word, registered.
- `stall`  out  1  high while an access is in progress; the requester must hold `cs`, `wr`, `mask`, `addr` and `data_wr` stable while it is high.
- `fault`  out  1  one-cycle pulse when a completed access was out of range.

## Operation
- FSM states: IDLE, BUSY, DONE. A cycle counter `wcnt` is 3 bits wide.
- **IDLE:**
  - `cs`=1: nothing happens.
  - `cs`=0: latch `wr`, `mask`, `data_wr`, the word index and the range result into request registers.
  - Then, if `WAIT_STATES`=0, go to DONE; otherwise load `wcnt`=`WAIT_STATES`-1 and go to BUSY.
- **BUSY:** if `wcnt`=0, go to DONE; otherwise decrement `wcnt`. Inputs are ignored; the latched copies are used.
- **Commit:** happens on the edge that enters DONE.
  - Store, in range: write each byte lane whose `mask` bit is 1. Other lanes are unchanged.
  - Load, in range: `data_rd` <= full word at the index.
  - Load, out of range: `data_rd` <= 0.
  - Store, out of range: nothing is written.
  - A store never changes `data_rd`.
- **DONE:** one cycle. `data_rd` is valid and `fault` is 1 if the access was out of range. Next state is always IDLE, and `cs` is not sampled in DONE.
- Range check: in range iff `BASE_ADDR` <= `addr` < `BASE_ADDR` + 4·`DEPTH_WORDS`. Compute it in 33-bit arithmetic so the window may end at 2^32.
- Word index = (`addr` − `BASE_ADDR`)[log2(`DEPTH_WORDS`)+1:2].
- `stall` is combinational: (state=IDLE and `cs`=0) or state=BUSY. It is 0 in DONE.
- A store with `mask`=0 completes normally: no change, no fault.
- `mask` is ignored for loads.
- Memory array contents are not reset and are undefined after power-up.

## Timing
- Reset values: state=IDLE, `wcnt`=0, `data_rd`=0, `fault`=0. `stall`=0 whenever `rst`=1, regardless of `cs`.
- Call the first cycle with `cs`=0 in IDLE cycle 0 (C0).
  - `stall` is high in C0..C`WAIT_STATES`.
  - DONE is cycle C`WAIT_STATES`+1. `data_rd` and `fault` are valid there.
- Occupancy is `WAIT_STATES`+2 cycles per access. The next request is accepted no earlier than the cycle after DONE.
- Read-after-write to the same word, back to back, returns the newly written bytes.
- `data_rd` holds its value until the next load's commit or a reset.
- Reset mid-access (`rst` asserted in C0 or in BUSY):
  - Abort; next state is IDLE.
  - A pending store is not committed.
  - `data_rd` is cleared to 0.
- Reset in DONE: the commit has already happened. Outputs clear on that edge.

## Test plan
- Word store then load, `WAIT_STATES`=1, `BASE_ADDR`=0: store 32'hDEADBEEF to 0x10 with `mask`=1111, then load 0x10 -> `stall` high for 2 cycles on each access; `data_rd`=32'hDEADBEEF in the load's DONE cycle; `fault`=0.
- Byte masking: preload 0x20 with 32'h11223344, store `data_wr`=32'hAA00_0000 with `mask`=1000, then store 32'h0000_BB00 with `mask`=0010, then load 0x20 -> 32'hAA22BB44.
- Out of range, `DEPTH_WORDS`=16 and `BASE_ADDR`=0x100: store to 0x140, then load 0x140 -> `fault` pulses in each DONE cycle; `data_rd`=0; word 0x13C is unchanged. Also load 0xFC -> `fault`=1.
- Wait-state sweep, `WAIT_STATES`=0 and 7: time from first `cs`=0 to DONE is 1 and 8 cycles respectively; `stall` is high exactly 1 and 8 cycles.
- Reset mid-access, `WAIT_STATES`=3: preload 0x8 with 32'h0; store 32'hFFFFFFFF to 0x8 and assert `rst` in the second BUSY cycle; then load 0x8 -> returns 32'h0; `stall`=0 during reset; `data_rd`=0 after reset.
- Back-to-back pipeline: hold `cs`=0 across two different loads, with the requester changing `addr` in the cycle after DONE -> the second access starts in IDLE and returns the second word; no access is skipped or duplicated.
